// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared types and constants for the instruction fetch front end.
//   INSTR_W         width of one instruction word
//   DEFAULT_ADDR_W  word-address width the stage is normally built with
//   FetchState      fetch FSM states (normal run / one-cycle redirect bubble)
//   FetchEntry      one buffered fetch result {instruction word, its PC}
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int INSTR_W        = 32;
    localparam int DEFAULT_ADDR_W = 8;

    typedef enum logic [0:0] {
        FS_RUN      = 1'b0,
        FS_REDIRECT = 1'b1
    } FetchState;

    // The top level re-declares this layout at its own ADDR_W; this one is
    // the default element type of the output buffer.
    typedef struct packed {
        logic [INSTR_W-1:0]        instr;
        logic [DEFAULT_ADDR_W-1:0] pc;
    } FetchEntry;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Bundles every non-clock/reset signal of the fetch stage.
//   imem_en / imem_addr / imem_data          synchronous instruction memory
//   branch_taken / branch_pc / branch_delta  redirect request from Execute
//   out_valid / out_ready / out_instr / out_pc  handshake towards Decode
// Modports:
//   master  the fetch stage itself
//   slave   its environment (memory, Execute and Decode)
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    import instr_fetch_pkg::*;

    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;

    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_pc;
    logic [31:0]        branch_delta;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_data,
        input  branch_taken,
        input  branch_pc,
        input  branch_delta,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_data,
        output branch_taken,
        output branch_pc,
        output branch_delta,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// ---------------------------------------------------------------------------
// instr_fetch_fifo
// Small circular buffer holding fetched words until Decode takes them.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   flush        synchronous clear; wins over push and pop in the same cycle
//   push         write push_data (ignored when full unless a pop frees a slot)
//   push_data    entry to write
//   pop          discard the head entry (ignored when empty)
//   head         entry at the head of the buffer
//   valid        buffer holds at least one entry
//   count        number of entries held
// ---------------------------------------------------------------------------
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = FetchEntry,
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full buffer is still accepted when the head leaves in
    // the same cycle, which is what keeps one word per cycle flowing.
    always_comb begin
        do_pop  = rst_n && !flush && pop && (count != '0);
        do_push = rst_n && !flush && push &&
                  ((count != CNT_W'(DEPTH)) || do_pop);
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: nothing is read out while count is zero.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_comb begin
        head  = mem[rd_ptr];
        valid = (count != '0);
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Front-end stage: owns the program counter, reads a synchronous instruction
// memory (data returns the cycle after imem_en), buffers results in a small
// FIFO and hands them to Decode over a valid/ready handshake. A taken branch
// from Execute redirects the PC to branch_pc + branch_delta (modulo
// 2**ADDR_W), flushes the buffer and drops the read that is in flight.
// Parameters:
//   ADDR_W      word-address width, PC wraps modulo 2**ADDR_W
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  output buffer entries (power of two, >= 2)
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    instr_fetch_if.master: memory, branch and Decode signals
// ---------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    FetchState          state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  req_pc;
    logic               inflight;

    logic [CNT_W-1:0]   count;
    logic               fifo_valid;
    entry_t             head;
    entry_t             push_entry;

    logic               pop;
    logic               push;
    logic               room;
    logic               issue;
    logic [OCC_W-1:0]   occupancy;

    // Issue decision. Occupancy counts the read already in flight, because
    // its word lands in the buffer next edge, minus the word Decode takes
    // this cycle. A taken branch squashes the word returning right now, so
    // it is never pushed; with one-cycle memory latency that is the only
    // read that can be in flight when the redirect happens.
    always_comb begin
        pop        = fifo_valid && bus.out_ready;
        occupancy  = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
        room       = occupancy < OCC_W'(FIFO_DEPTH);
        issue      = rst_n && (state == FS_RUN) && room && !bus.branch_taken;
        push       = inflight && !bus.branch_taken;
        push_entry = '{instr: bus.imem_data, pc: req_pc};
    end

    // PC, FSM and in-flight tracking. REDIRECT is a single bubble cycle that
    // gives the memory a clean slate; a further branch during it simply
    // re-targets the PC and stays there one more cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FS_RUN;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc <= fetch_pc;
            end
            if (bus.branch_taken) begin
                state    <= FS_REDIRECT;
                fetch_pc <= bus.branch_pc + bus.branch_delta[ADDR_W-1:0];
            end else begin
                state <= FS_RUN;
                if (issue) begin
                    fetch_pc <= fetch_pc + ADDR_W'(1);
                end
            end
        end
    end

    instr_fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.branch_taken),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .valid     (fifo_valid),
        .count     (count)
    );

    // Data outputs read as zero whenever nothing valid is presented, so
    // stale buffer contents never leak out after reset or a flush.
    always_comb begin
        bus.imem_en   = issue;
        bus.imem_addr = fetch_pc;
        bus.out_valid = fifo_valid;
        bus.out_instr = fifo_valid ? head.instr : '0;
        bus.out_pc    = fifo_valid ? head.pc    : '0;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. A behavioural ROM returns 0x1000 + address
// one cycle after imem_en. Inputs change at the falling edge and outputs are
// compared 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch #(
        .ADDR_W     (ADDR_W),
        .RESET_PC   (8'h00),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Synchronous instruction ROM: word at address a is 0x1000 + a.
    always @(posedge clk) begin
        if (bus.imem_en) begin
            bus.imem_data <= 32'h0000_1000 + 32'(bus.imem_addr);
        end
    end

    typedef struct {
        logic        rst_n;
        logic        ready;
        logic        exp_valid;
        logic        exp_en;
        logic [7:0]  exp_pc;
        logic [31:0] exp_instr;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic ready, input logic br,
                                  input logic [7:0] bpc, input logic [31:0] bdelta);
        @(negedge clk);
        rst_n            = rst;
        bus.out_ready    = ready;
        bus.branch_taken = br;
        bus.branch_pc    = bpc;
        bus.branch_delta = bdelta;
        #1;
    endtask

    // Runs cycles with out_ready=1 until out_valid is seen; n is the number
    // of cycles stepped. An expired budget shows up as a failed check.
    task automatic wait_valid(input string name, input int max_cycles, output int n);
        n = 0;
        do begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
            n++;
        end while (!bus.out_valid && n < max_cycles);
        check_output({name, " valid seen"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bus.out_ready    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_pc    = '0;
        bus.branch_delta = '0;

        //                rst  rdy  vld  en   pc     instr
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0,    "reset"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,    "rel c0"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,    "rel c1"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 32'h1000, "first"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 32'h1001, "stream1"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 32'h1002, "stream2"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 32'h1003, "stream3"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 32'h1004, "midreset"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,    "after rst"});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0,    "restart1"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h1000, "stall0"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h1000, "stall1"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h1000, "stall2"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h1000, "stall3"});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h1000, "stall4"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 32'h1000, "drain0"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 32'h1001, "drain1"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 32'h1002, "drain2"});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 32'h1003, "drain3"});

        $display("[TB] reset, streaming, mid-run reset and stall vectors");
        do_reset();
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst_n, vecs[i].ready, 1'b0, 8'h00, 32'h0);
            check_output({vecs[i].tag, " out_valid"}, 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            check_output({vecs[i].tag, " imem_en"}, 32'(bus.imem_en), 32'(vecs[i].exp_en));
            if (vecs[i].exp_valid || !vecs[i].rst_n) begin
                check_output({vecs[i].tag, " out_pc"}, 32'(bus.out_pc), 32'(vecs[i].exp_pc));
                check_output({vecs[i].tag, " out_instr"}, bus.out_instr, vecs[i].exp_instr);
            end
        end

        $display("[TB] branch while the buffer is full");
        do_reset();
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        end
        check_output("full imem_en", 32'(bus.imem_en), 32'd0);
        check_output("full out_pc", 32'(bus.out_pc), 32'h00);
        apply_stimulus(1'b1, 1'b0, 1'b1, 8'h05, 32'd10);
        check_output("branch imem_en", 32'(bus.imem_en), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        check_output("redirect out_valid", 32'(bus.out_valid), 32'd0);
        check_output("redirect imem_en", 32'(bus.imem_en), 32'd0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        check_output("target out_valid", 32'(bus.out_valid), 32'd0);
        check_output("target imem_en", 32'(bus.imem_en), 32'd1);
        check_output("target imem_addr", 32'(bus.imem_addr), 32'h0F);
        wait_valid("target", 8, n);
        check_output("target latency", 32'(n), 32'd2);
        check_output("target out_pc", 32'(bus.out_pc), 32'h0F);
        check_output("target out_instr", bus.out_instr, 32'h100F);
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
        check_output("target+1 out_pc", 32'(bus.out_pc), 32'h10);

        $display("[TB] negative delta with address wrap");
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'hFE, 32'hFFFF_FF01);
        check_output("wrap branch out_valid", 32'(bus.out_valid), 32'd1);
        wait_valid("wrap", 8, n);
        check_output("wrap latency", 32'(n), 32'd4);
        check_output("wrap out_pc", 32'(bus.out_pc), 32'hFF);
        check_output("wrap out_instr", bus.out_instr, 32'h10FF);
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
        check_output("wrapped out_pc", 32'(bus.out_pc), 32'h00);
        check_output("wrapped out_instr", bus.out_instr, 32'h1000);

        $display("[TB] branch coinciding with capture and pop");
        apply_stimulus(1'b1, 1'b1, 1'b0, 8'h00, 32'h0);
        check_output("pre out_pc", 32'(bus.out_pc), 32'h01);
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h30, 32'h10);
        check_output("coincide out_valid", 32'(bus.out_valid), 32'd1);
        check_output("coincide out_pc", 32'(bus.out_pc), 32'h02);
        wait_valid("coincide", 8, n);
        check_output("coincide target pc", 32'(bus.out_pc), 32'h40);
        check_output("coincide target instr", bus.out_instr, 32'h1040);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
